seq_divider: RTL and testbench

- Multi-cycle restoring shift-subtract divider for the MIPS-Lite EX stage.
- Executes DIV (signed) and DIVU (unsigned).
- Returns the quotient to LO and the remainder to HI.
- Uses a start/busy/done handshake so the pipeline stalls while `busy` is high.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_sub_stage.sv | 24 ++
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width
// and the quotient pattern returned on divide-by-zero.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Wide enough for any WIDTH up to 64; callers truncate with a WIDTH'() cast.
    localparam logic [63:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtractor for one restoring-division step: a - b as a ripple chain of full adders.
// Combinational, no flow control; nonneg_o is the final carry (1 when a >= b).
module div_sub_stage #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         nonneg_o
);

    logic carry;

    always_comb begin
        diff_o = '0;
        carry  = 1'b1;
        for (int i = 0; i < W; i++) begin
            diff_o[i] = a_i[i] ^ ~b_i[i] ^ carry;
            carry     = (a_i[i] & ~b_i[i]) | (carry & (a_i[i] ^ ~b_i[i]));
        end
        nonneg_o = carry;
    end

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract DIV/DIVU: quotient -> LO, remainder -> HI, WIDTH+2 cycles incl. accept.
// start is ignored while busy (and in the FINISH cycle); divide-by-zero completes one cycle after accept.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] dvd_raw_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_out_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   trial_diff;
    logic [WIDTH:0]   rem_next;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic             rem_msb_unused;

    // Unsigned magnitudes: the most-negative value maps to 2^(WIDTH-1) with no overflow.
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;

    assign shifted_rem = {rem_q, quo_q[WIDTH-1]};

    div_sub_stage #(
        .W (WIDTH + 1)
    ) u_sub (
        .a_i      (shifted_rem),
        .b_i      ({1'b0, dvsr_q}),
        .diff_o   (trial_diff),
        .nonneg_o (trial_ok)
    );

    // The partial remainder is always below the divisor, so its top bit is zero after each step.
    assign rem_next       = trial_ok ? trial_diff : shifted_rem;
    assign rem_d          = rem_next[WIDTH-1:0];
    assign rem_msb_unused = rem_next[WIDTH];
    assign quo_d          = {quo_q[WIDTH-2:0], trial_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dvd_raw_q   <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        quo_q     <= dvd_mag;
                        dvsr_q    <= dvs_mag;
                        dvd_raw_q <= dividend;
                        neg_quo_q <= dvd_neg ^ dvs_neg;
                        neg_rem_q <= dvd_neg;
                        dbz_q     <= (divisor == '0);
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= (divisor == '0) ? FINISH : CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    if (dbz_q) begin
                        quotient_q  <= WIDTH'(ALL_ONES);
                        remainder_q <= dvd_raw_q;
                    end else begin
                        quotient_q  <= neg_quo_q ? -quo_q : quo_q;
                        remainder_q <= neg_rem_q ? -rem_q : rem_q;
                    end
                    dbz_out_q <= dbz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed MIPS DIV/DIVU cases, start-while-busy,
// reset abort and randomised operands checked against a magnitude model and the division invariant.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    seq_divider #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        bit          sa, sb;
        logic [31:0] ma, mb, q, r;
        e.a = a;
        e.b = b;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
            return e;
        end
        sa = s & a[31];
        sb = s & b[31];
        ma = sa ? (32'd0 - a) : a;
        mb = sb ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        e.q   = (sa ^ sb) ? (32'd0 - q) : q;
        e.r   = sa ? (32'd0 - r) : r;
        e.dbz = 1'b0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("quotient",    quotient,    mon_e.q);
                check("remainder",   remainder,   mon_e.r);
                check("div_by_zero", div_by_zero, mon_e.dbz);
                if (mon_e.b != 32'd0) begin
                    check("invariant", 32'(quotient * mon_e.b + remainder), mon_e.a);
                end
            end
        end
    end

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; pokes start at cycles 10 and 33 if asked.
    task automatic wait_done(input bit poke, output int lat);
        int busy_bad;
        busy_bad = (busy !== 1'b1) ? 1 : 0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (poke) begin
                start     = (n == 9 || n == 32);
                is_signed = 1'b0;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;
        check("busy_span", busy_bad, 0);
    endtask

    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic dbz,
                          input int exp_lat, input bit poke);
        int lat;
        sb_q.push_back({q, r, dbz, a, b});
        issue(s, a, b);
        wait_done(poke, lat);
        check("latency", lat, exp_lat);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        exp_t e;
        bit   s;
        logic [31:0] a, b;

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      busy,        0);
        check("rst_done",      done,        0);
        check("rst_quotient",  quotient,    0);
        check("rst_remainder", remainder,   0);
        check("rst_dbz",       div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 33, 0);
        run_op(1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
        run_op(1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 33, 0);
        run_op(1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 33, 0);
        run_op(0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 33, 0);
        run_op(0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1,        1'b0, 33, 0);
        run_op(0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1,  0);
        run_op(1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1,  0);

        // start pulses while busy and in the final cycle must not disturb 100/7.
        run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1);
        @(posedge clk);
        run_op(0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33, 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_ops", busy, 0);

        // Reset in cycle 15 aborts the divide with no done pulse.
        issue(0, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy",      busy,        0);
        check("abort_done",      done,        0);
        check("abort_quotient",  quotient,    0);
        check("abort_remainder", remainder,   0);
        check("abort_dbz",       div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle", busy, 0);
        run_op(0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);

        for (int i = 0; i < 2000; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            e = model(s, a, b);
            sb_q.push_back(e);
            issue(s, a, b);
            wait_done(0, lat);
            check("rand_latency", lat, (b == 32'd0) ? 1 : 33);
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
